// File: rtl/soil_filter_pkg.sv
// soil_filter_pkg: shared widths, channel count and FSM states for the soil-moisture filter
package soil_filter_pkg;
    localparam int NUM_CH = 3;
    localparam int ADC_W = 12;
    localparam logic [ADC_W-1:0] ADC_MAX = 12'hFFF;
    typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, PUBLISH} state_t;
endpackage

// File: rtl/adc_ring_buf.sv
// adc_ring_buf: per-channel sample history, synchronous write, combinational read at the shared pointer
module adc_ring_buf
    import soil_filter_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [ADC_W-1:0] wdata,
    output logic [ADC_W-1:0] rdata
);
    logic [ADC_W-1:0] mem [2**AW];
    assign rdata = mem[addr];
    always_ff @(posedge clk_50) begin
        if (reset) for (int k = 0; k < 2**AW; k++) mem[k] <= '0;
        else if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/adc_moisture_filter.sv
// adc_moisture_filter: sliding-window averages and hysteresis dry flags for 3 ADC channels; STUCK_DETECT_EN adds rail-stuck flags
module adc_moisture_filter
    import soil_filter_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int DRY_LO = 1500,
    parameter int DRY_HI = 1700,
    parameter int STUCK_N = 8
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic [ADC_W-1:0]  ch0_data,
    input  logic [ADC_W-1:0]  ch1_data,
    input  logic [ADC_W-1:0]  ch2_data,
    output logic [ADC_W-1:0]  avg0,
    output logic [ADC_W-1:0]  avg1,
    output logic [ADC_W-1:0]  avg2,
    output logic              avg_valid,
    output logic [NUM_CH-1:0] dry,
    output logic              primed,
    output logic              overrun
`ifdef STUCK_DETECT_EN
    ,
    output logic [NUM_CH-1:0] stuck
`endif
);
    localparam int SW = ADC_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(1 << AVG_LOG2);
    localparam logic [ADC_W-1:0] LO = ADC_W'(DRY_LO);
    localparam logic [ADC_W-1:0] HI = ADC_W'(DRY_HI);

    if (AVG_LOG2 < 1 || AVG_LOG2 > 4 || DRY_HI <= DRY_LO || STUCK_N < 1) begin : g_bad_param
        $error("adc_moisture_filter: illegal parameter set");
    end

    state_t state;
    logic [AVG_LOG2-1:0] wptr;
    logic [AVG_LOG2:0] fill, fill_n;
    logic [ADC_W-1:0] din [NUM_CH];
    logic [ADC_W-1:0] cap [NUM_CH];
    logic [ADC_W-1:0] rd [NUM_CH];
    logic [ADC_W-1:0] avg [NUM_CH];
    logic [ADC_W-1:0] avg_n [NUM_CH];
    logic [SW-1:0] sum [NUM_CH];
    logic [SW-1:0] acc;
    logic [1:0] sel;
    logic upd;

    assign din[0] = ch0_data;
    assign din[1] = ch1_data;
    assign din[2] = ch2_data;
    assign avg0 = avg[0];
    assign avg1 = avg[1];
    assign avg2 = avg[2];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        adc_ring_buf #(.AW(AVG_LOG2)) u_buf (
            .clk_50(clk_50),
            .reset(reset),
            .we(upd && sel == 2'(i)),
            .addr(wptr),
            .wdata(cap[i]),
            .rdata(rd[i])
        );
        assign avg_n[i] = sum[i][SW-1:AVG_LOG2];
    end

    // Single add/sub shared by the three UPD states; the true result always fits in SW bits
    always_comb begin
        upd = state inside {UPD0, UPD1, UPD2};
        sel = state == UPD1 ? 2'd1 : state == UPD2 ? 2'd2 : 2'd0;
        acc = sum[sel] + SW'(cap[sel]) - SW'(rd[sel]);
        fill_n = fill == FULL ? fill : fill + 1'b1;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state <= IDLE;
            wptr <= '0;
            fill <= '0;
            primed <= 1'b0;
            avg_valid <= 1'b0;
            dry <= '0;
            overrun <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                cap[c] <= '0;
                sum[c] <= '0;
                avg[c] <= '0;
            end
        end else begin
            avg_valid <= 1'b0;
            if (sample_tick && state != IDLE) overrun <= 1'b1;
            if (upd) sum[sel] <= acc;
            case (state)
                IDLE: if (sample_tick) begin
                    cap <= din;
                    state <= UPD0;
                end
                UPD0: state <= UPD1;
                UPD1: state <= UPD2;
                UPD2: state <= PUBLISH;
                default: begin
                    state <= IDLE;
                    wptr <= wptr + 1'b1;
                    fill <= fill_n;
                    primed <= fill_n == FULL;
                    avg_valid <= fill_n == FULL;
                    avg <= avg_n;
                    for (int c = 0; c < NUM_CH; c++)
                        if (fill_n == FULL) dry[c] <= avg_n[c] < LO ? 1'b1 : avg_n[c] > HI ? 1'b0 : dry[c];
                end
            endcase
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int CW = $clog2(STUCK_N + 1);
    localparam logic [CW-1:0] SN = CW'(STUCK_N);
    logic [CW-1:0] cnt [NUM_CH];
    logic [CW-1:0] cnt_n [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            cnt_n[c] = (cap[c] == '0 || cap[c] == ADC_MAX) ? (cnt[c] == SN ? cnt[c] : cnt[c] + 1'b1) : '0;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            stuck <= '0;
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
        end else if (state == PUBLISH) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= cnt_n[c];
                stuck[c] <= cnt_n[c] >= SN;
            end
        end
    end
`endif
endmodule

// File: tb/tb_adc_moisture_filter.sv
// tb_adc_moisture_filter: randomized scenarios checked against a queue-based window-average model
module tb_adc_moisture_filter;
    localparam int D = 4;

    logic clk_50 = 1'b0;
    logic reset = 1'b1;
    logic sample_tick = 1'b0;
    logic [11:0] ch0_data = '0, ch1_data = '0, ch2_data = '0;
    logic [11:0] avg0, avg1, avg2;
    logic avg_valid, primed, overrun;
    logic [2:0] dry;
`ifdef STUCK_DETECT_EN
    logic [2:0] stuck;
`endif
    logic [11:0] got [3];
    int checks = 0, errors = 0;
    int hist [3][$];
    int rails [3];
    int m_count, vcount, vlat;
    logic [2:0] m_dry;

    always #5 clk_50 = ~clk_50;
    assign got[0] = avg0;
    assign got[1] = avg1;
    assign got[2] = avg2;

    adc_moisture_filter dut (
        .clk_50(clk_50),
        .reset(reset),
        .sample_tick(sample_tick),
        .ch0_data(ch0_data),
        .ch1_data(ch1_data),
        .ch2_data(ch2_data),
        .avg0(avg0),
        .avg1(avg1),
        .avg2(avg2),
        .avg_valid(avg_valid),
        .dry(dry),
        .primed(primed),
        .overrun(overrun)
`ifdef STUCK_DETECT_EN
        ,
        .stuck(stuck)
`endif
    );

    function automatic int m_avg(input int c);
        int s = 0;
        for (int k = 0; k < hist[c].size(); k++) s += hist[c][k];
        return s / D;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            hist[c].delete();
            rails[c] = 0;
        end
        m_count = 0;
        m_dry = '0;
    endfunction

    function automatic void model_push(input int a, input int b, input int x);
        int s [3] = '{a, b, x};
        m_count++;
        for (int c = 0; c < 3; c++) begin
            hist[c].push_back(s[c]);
            if (hist[c].size() > D) void'(hist[c].pop_front());
            rails[c] = (s[c] == 0 || s[c] == 4095) ? rails[c] + 1 : 0;
            if (m_count >= D) m_dry[c] = m_avg(c) < 1500 ? 1'b1 : m_avg(c) > 1700 ? 1'b0 : m_dry[c];
        end
    endfunction

    task automatic watch(input int n);
        vcount = 0;
        vlat = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_50); #1;
            if (avg_valid) begin
                vcount++;
                vlat = k;
            end
        end
    endtask

    task automatic send(input int a, input int b, input int x, input int gap);
        ch0_data = 12'(a);
        ch1_data = 12'(b);
        ch2_data = 12'(x);
        sample_tick = 1'b1;
        @(posedge clk_50); #1 sample_tick = 1'b0;
        model_push(a, b, x);
        watch(gap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_50); #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sample_tick = 1'b1;
        ch0_data = 12'd1234;
        ch1_data = 12'd1234;
        ch2_data = 12'd1234;
        repeat (3) @(posedge clk_50);
        #1;
        checks++;
        if ({avg0, avg1, avg2, avg_valid, dry, primed, overrun} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {avg0, avg1, avg2, avg_valid, dry, primed, overrun});
        end
        reset = 1'b0;
        sample_tick = 1'b0;
        model_reset();
        watch(6);
        checks++;
        if (vcount !== 0 || overrun !== 1'b0 || primed !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick_ignored: valid=%0d overrun=%b primed=%b required 0 0 0", vcount, overrun, primed);
        end
    endtask

    task automatic test_constant();
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            send(1000, 1000, 1000, 15);
            checks++;
            if (vcount !== (t == 4 ? 1 : 0)) begin
                errors++;
                $display("FAIL const_valid tick %0d: got %0d pulses required %0d", t, vcount, t == 4 ? 1 : 0);
            end
            checks++;
            if (primed !== (t == 4)) begin
                errors++;
                $display("FAIL const_primed tick %0d: got %b required %b", t, primed, t == 4);
            end
            checks++;
            if (avg0 !== 12'(250 * t)) begin
                errors++;
                $display("FAIL const_ramp tick %0d: got %0d required %0d", t, avg0, 250 * t);
            end
        end
        checks++;
        if (vlat !== 4) begin
            errors++;
            $display("FAIL const_latency: got %0d required 4 cycles after capture", vlat);
        end
        checks++;
        if ({avg0, avg1, avg2} !== {3{12'd1000}}) begin
            errors++;
            $display("FAIL const_avg: got %0d %0d %0d required 1000", avg0, avg1, avg2);
        end
        checks++;
        if (dry !== 3'b111) begin
            errors++;
            $display("FAIL const_dry: got %b required 111", dry);
        end
    endtask

    task automatic test_ramp();
        int exp0 [4] = '{1023, 2047, 3071, 4095};
        do_reset();
        for (int t = 1; t <= 8; t++) begin
            send(t <= 4 ? 0 : 4095, $urandom_range(0, 4095), $urandom_range(0, 4095), 15);
            if (t > 4) begin
                checks++;
                if (avg0 !== 12'(exp0[t-5])) begin
                    errors++;
                    $display("FAIL ramp_avg0 tick %0d: got %0d required %0d", t, avg0, exp0[t-5]);
                end
            end
            for (int c = 1; c < 3; c++) begin
                checks++;
                if (got[c] !== 12'(m_avg(c))) begin
                    errors++;
                    $display("FAIL ramp_avg%0d tick %0d: got %0d required %0d", c, t, got[c], m_avg(c));
                end
            end
            checks++;
            if (dry !== m_dry) begin
                errors++;
                $display("FAIL ramp_dry tick %0d: got %b required %b", t, dry, m_dry);
            end
        end
    endtask

    task automatic test_hysteresis();
        int lvl [4] = '{1600, 1400, 1600, 1800};
        logic expd [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int t = 0; t < 4; t++) begin
                send($urandom_range(0, 4095), lvl[p], $urandom_range(0, 4095), 15);
                checks++;
                if (dry !== m_dry) begin
                    errors++;
                    $display("FAIL hyst_dry level %0d step %0d: got %b required %b", lvl[p], t, dry, m_dry);
                end
            end
            checks++;
            if (dry[1] !== expd[p]) begin
                errors++;
                $display("FAIL hyst_dry1 at %0d: got %b required %b", lvl[p], dry[1], expd[p]);
            end
        end
    endtask

    task automatic test_overrun();
        int a = $urandom_range(0, 4095), b = $urandom_range(0, 4095), x = $urandom_range(0, 4095);
        ch0_data = 12'(a);
        ch1_data = 12'(b);
        ch2_data = 12'(x);
        sample_tick = 1'b1;
        @(posedge clk_50); #1 sample_tick = 1'b0;
        model_push(a, b, x);
        @(posedge clk_50); #1;
        ch0_data = 12'($urandom_range(0, 4095));
        ch1_data = 12'($urandom_range(0, 4095));
        ch2_data = 12'($urandom_range(0, 4095));
        sample_tick = 1'b1;
        @(posedge clk_50); #1 sample_tick = 1'b0;
        watch(10);
        checks++;
        if (vcount !== 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d required 1", vcount);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (got[c] !== 12'(m_avg(c))) begin
                errors++;
                $display("FAIL overrun_avg%0d: got %0d required %0d", c, got[c], m_avg(c));
            end
        end
        send($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095), 15);
        checks++;
        if (overrun !== 1'b1 || vcount !== 1) begin
            errors++;
            $display("FAIL overrun_sticky: overrun=%b valid=%0d required 1 1", overrun, vcount);
        end
    endtask

    task automatic test_reset_mid();
        ch0_data = 12'd3000;
        sample_tick = 1'b1;
        @(posedge clk_50); #1 sample_tick = 1'b0;
        @(posedge clk_50); #1 reset = 1'b1;
        @(posedge clk_50); #1 reset = 1'b0;
        model_reset();
        watch(8);
        checks++;
        if (vcount !== 0) begin
            errors++;
            $display("FAIL midreset_valid: got %0d pulses required 0", vcount);
        end
        checks++;
        if ({avg0, avg1, avg2, avg_valid, dry, primed, overrun} !== 42'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h required 0", {avg0, avg1, avg2, avg_valid, dry, primed, overrun});
        end
        for (int t = 1; t <= 4; t++) send(500, 500, 500, 15);
        checks++;
        if ({avg0, avg1, avg2} !== {3{12'd500}} || primed !== 1'b1 || vcount !== 1) begin
            errors++;
            $display("FAIL midreset_refill: avg %0d %0d %0d primed=%b valid=%0d required 500 1 1", avg0, avg1, avg2, primed, vcount);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int t = 1; t <= 12; t++) begin
            send($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095), 4);
            checks++;
            if (vcount !== (m_count >= D ? 1 : 0)) begin
                errors++;
                $display("FAIL b2b_valid tick %0d: got %0d required %0d", t, vcount, m_count >= D ? 1 : 0);
            end
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (got[c] !== 12'(m_avg(c))) begin
                    errors++;
                    $display("FAIL b2b_avg%0d tick %0d: got %0d required %0d", c, t, got[c], m_avg(c));
                end
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b required 0", overrun);
        end
    endtask

    task automatic test_random();
        int s [3];
        do_reset();
        for (int t = 1; t <= 40; t++) begin
            for (int c = 0; c < 3; c++) s[c] = $urandom_range(0, 1) ? $urandom_range(0, 4095) : $urandom_range(1300, 1900);
            send(s[0], s[1], s[2], $urandom_range(4, 20));
            checks++;
            if (vcount !== (m_count >= D ? 1 : 0) || primed !== (m_count >= D)) begin
                errors++;
                $display("FAIL rand_valid tick %0d: valid=%0d primed=%b required %0d", t, vcount, primed, m_count >= D ? 1 : 0);
            end
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (got[c] !== 12'(m_avg(c))) begin
                    errors++;
                    $display("FAIL rand_avg%0d tick %0d: got %0d required %0d", c, t, got[c], m_avg(c));
                end
            end
            checks++;
            if (dry !== m_dry) begin
                errors++;
                $display("FAIL rand_dry tick %0d: got %b required %b", t, dry, m_dry);
            end
        end
    endtask

`ifdef STUCK_DETECT_EN
    task automatic test_stuck();
        do_reset();
        for (int t = 1; t <= 9; t++) begin
            send($urandom_range(1, 4094), $urandom_range(0, 1) ? 0 : 2048, t <= 8 ? 4095 : 2000, 15);
            checks++;
            if (stuck !== {rails[2] >= 8, rails[1] >= 8, rails[0] >= 8}) begin
                errors++;
                $display("FAIL stuck_model tick %0d: got %b required %b", t, stuck, {rails[2] >= 8, rails[1] >= 8, rails[0] >= 8});
            end
            if (t >= 8) begin
                checks++;
                if (stuck[2] !== (t == 8)) begin
                    errors++;
                    $display("FAIL stuck_ch2 tick %0d: got %b required %b", t, stuck[2], t == 8);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_hysteresis();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef STUCK_DETECT_EN
        test_stuck();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
